// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit serializer and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int   UART_DEFAULT_OVERSAMPLE = 8;
  localparam int   UART_DEFAULT_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL         = 1'b1;

  // Receiver samples each bit at the middle of its oversample window.
  function automatic int uart_sample_point(input int oversample);
    return oversample / 2;
  endfunction

endpackage

// File: rtl/uart_tick_counter.sv
// Modulo-OVERSAMPLE counter of enable pulses; o_wrap marks the pulse that
// completes a bit period.
module uart_tick_counter
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_DEFAULT_OVERSAMPLE
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_wrap
);

  localparam int              W   = $clog2(OVERSAMPLE);
  localparam logic [W-1:0]    MAX = W'(OVERSAMPLE - 1);

  logic [W-1:0] r_count;
  logic         w_at_max;

  assign w_at_max = (r_count == MAX);
  assign o_wrap   = i_enable & w_at_max;

  // Count enable pulses, wrapping to zero at the end of each bit period.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= w_at_max ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, LSB-first data, optional even parity and
// one or two stop bits, each bit lasting OVERSAMPLE enable pulses.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_DEFAULT_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DEFAULT_DATA_BITS,
  parameter int PARITY_EN  = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 txStart,
  input  logic [DATA_BITS-1:0] txDataIn,
  output logic                 txDataOut,
  output logic                 txBusy,
  output logic                 txDone
);

  localparam int             BCW       = $clog2(DATA_BITS + 1);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS - 1);
  localparam logic           LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_e          r_state,   w_state;
  logic [DATA_BITS-1:0] r_shift,   w_shift;
  logic [BCW-1:0]       r_bit_cnt, w_bit_cnt;
  logic                 r_stop_cnt, w_stop_cnt;
  logic                 r_parity,  w_parity;
  logic                 r_line,    w_line;
  logic                 r_busy,    w_busy;
  logic                 r_done,    w_done;
  logic                 w_accept;
  logic                 w_tick_en;
  logic                 w_wrap;

  assign w_accept  = (r_state == IDLE) && txStart;
  // Ticks are only counted once a frame is underway, so an enable coinciding
  // with acceptance never shortens the start bit.
  assign w_tick_en = enable && (r_state != IDLE);

  uart_tick_counter #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .i_clk   (clk),
    .i_reset (reset),
    .i_clear (w_accept),
    .i_enable(w_tick_en),
    .o_wrap  (w_wrap)
  );

  // State and registered line/handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_parity   <= 1'b0;
      r_line     <= UART_IDLE_LEVEL;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_shift    <= w_shift;
      r_bit_cnt  <= w_bit_cnt;
      r_stop_cnt <= w_stop_cnt;
      r_parity   <= w_parity;
      r_line     <= w_line;
      r_busy     <= w_busy;
      r_done     <= w_done;
    end
  end

  // Next-state logic; the line value for the next bit is computed here so
  // the output can come straight from a register.
  always_comb begin
    w_state    = r_state;
    w_shift    = r_shift;
    w_bit_cnt  = r_bit_cnt;
    w_stop_cnt = r_stop_cnt;
    w_parity   = r_parity;
    w_line     = r_line;
    w_busy     = r_busy;
    w_done     = 1'b0;
    case (r_state)
      IDLE: begin
        w_line = UART_IDLE_LEVEL;
        if (txStart) begin
          w_state   = START;
          w_shift   = txDataIn;
          w_parity  = ^txDataIn;
          w_bit_cnt = '0;
          w_busy    = 1'b1;
          w_line    = 1'b0;
        end
      end
      START: begin
        if (w_wrap) begin
          w_state = DATA;
          w_line  = r_shift[0];
        end
      end
      DATA: begin
        if (w_wrap) begin
          w_shift   = {1'b0, r_shift[DATA_BITS-1:1]};
          w_bit_cnt = r_bit_cnt + 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              w_state = PARITY;
              w_line  = r_parity;
            end else begin
              w_state    = STOP;
              w_stop_cnt = 1'b0;
              w_line     = UART_IDLE_LEVEL;
            end
          end else begin
            w_line = w_shift[0];
          end
        end
      end
      PARITY: begin
        if (w_wrap) begin
          w_state    = STOP;
          w_stop_cnt = 1'b0;
          w_line     = UART_IDLE_LEVEL;
        end
      end
      STOP: begin
        if (w_wrap) begin
          if (r_stop_cnt == LAST_STOP) begin
            w_state = IDLE;
            w_busy  = 1'b0;
            w_done  = 1'b1;
          end else begin
            w_stop_cnt = 1'b1;
          end
        end
      end
      default: begin
        w_state = IDLE;
        w_line  = UART_IDLE_LEVEL;
        w_busy  = 1'b0;
      end
    endcase
  end

  assign txDataOut = r_line;
  assign txBusy    = r_busy;
  assign txDone    = r_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: two instances (8N1 and 8E2) driven with
// randomized enable spacing and spurious txStart, checked cycle by cycle
// against a frame built as a list of bit levels, each held OVERSAMPLE enables.
module tb_uart_tx_serializer;

  localparam int OS = 8;
  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       start0, start1;
  logic [7:0] data0, data1;
  logic       line0, busy0, done0;
  logic       line1, busy1, done1;

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen[2] = '{0, 0};
  int done_exp[2]  = '{0, 0};

  always #5 clk = ~clk;

  uart_tx_serializer #(
    .OVERSAMPLE(OS), .DATA_BITS(DB), .PARITY_EN(0), .STOP_BITS(1)
  ) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .txStart(start0),
    .txDataIn(data0), .txDataOut(line0), .txBusy(busy0), .txDone(done0)
  );

  uart_tx_serializer #(
    .OVERSAMPLE(OS), .DATA_BITS(DB), .PARITY_EN(1), .STOP_BITS(2)
  ) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .txStart(start1),
    .txDataIn(data1), .txDataOut(line1), .txBusy(busy1), .txDone(done1)
  );

  always @(posedge clk) begin
    if (done0) done_seen[0] <= done_seen[0] + 1;
    if (done1) done_seen[1] <= done_seen[1] + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic st, input logic [7:0] d);
    if (sel == 1) begin
      start1 = st;
      data1  = d;
    end else begin
      start0 = st;
      data0  = d;
    end
  endtask

  task automatic drive_noise(input int sel);
    if ($urandom % 4 == 0) drive(sel, 1'b1, ($urandom % 2 == 0) ? 8'hFF : 8'($urandom));
    else                   drive(sel, 1'b0, 8'($urandom));
  endtask

  task automatic check_outs(input int sel, input string tag, input logic l, input logic b, input logic d);
    check({tag, ".line"}, (sel == 1) ? line1 : line0, l);
    check({tag, ".busy"}, (sel == 1) ? busy1 : busy0, b);
    check({tag, ".done"}, (sel == 1) ? done1 : done0, d);
  endtask

  // Sends one byte. b2b: assert txStart in the current cycle (the previous
  // txDone cycle). stall_at: bit index at which enable is withheld 50 clk.
  // abort: reset during the 4th data bit instead of finishing.
  task automatic send(input int sel, input logic [7:0] d, input bit b2b,
                      input int stall_at, input bit abort);
    logic       bits[$];
    logic [7:0] rx;
    int         gap;
    bit         last;
    bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) bits.push_back(d[i]);
    if (sel == 1) bits.push_back(^d);
    for (int i = 0; i < ((sel == 1) ? 2 : 1); i++) bits.push_back(1'b1);

    if (!b2b) begin
      repeat ($urandom_range(1, 4)) begin
        drive(sel, 1'b0, 8'($urandom));
        enable = 1'($urandom);
        step();
        check_outs(sel, "idle", 1'b1, 1'b0, 1'b0);
      end
    end

    drive(sel, 1'b1, d);
    enable = 1'b1;
    step();
    check_outs(sel, "accept", 1'b0, 1'b1, 1'b0);

    rx = '0;
    for (int b = 0; b < bits.size(); b++) begin
      for (int k = 0; k < OS; k++) begin
        gap = (b == stall_at && k == 2) ? 50 : int'($urandom_range(0, 4));
        repeat (gap) begin
          enable = 1'b0;
          drive_noise(sel);
          step();
          check_outs(sel, "hold", bits[b], 1'b1, 1'b0);
        end
        if (abort && b == 4 && k == 3) begin
          reset  = 1'b1;
          enable = 1'b1;
          drive(sel, 1'b0, 8'($urandom));
          step();
          reset = 1'b0;
          check_outs(sel, "reset", 1'b1, 1'b0, 1'b0);
          repeat (8) begin
            enable = 1'($urandom);
            step();
            check_outs(sel, "post_reset", 1'b1, 1'b0, 1'b0);
          end
          return;
        end
        if (b >= 1 && b <= DB && k == OS / 2) rx[b-1] = (sel == 1) ? line1 : line0;
        enable = 1'b1;
        drive_noise(sel);
        step();
        enable = 1'b0;
        last = (b == bits.size() - 1) && (k == OS - 1);
        if (last)            check_outs(sel, "done", 1'b1, 1'b0, 1'b1);
        else if (k == OS - 1) check_outs(sel, "bit", bits[b+1], 1'b1, 1'b0);
        else                  check_outs(sel, "tick", bits[b], 1'b1, 1'b0);
      end
    end
    drive(sel, 1'b0, 8'($urandom));
    check("rx", rx, d);
    done_exp[sel]++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    data0  = '0;
    data1  = '0;
    step();
    step();
    check_outs(0, "rst0", 1'b1, 1'b0, 1'b0);
    check_outs(1, "rst1", 1'b1, 1'b0, 1'b0);
    reset = 1'b0;

    send(0, 8'hA5, 0, -1, 0);
    send(1, 8'hA5, 0, -1, 0);
    send(1, 8'h07, 1, -1, 0);
    send(0, 8'h3C, 0, -1, 0);
    send(0, 8'h81, 1, -1, 0);
    send(0, 8'h5A, 0, -1, 1);
    send(0, 8'h55, 0, -1, 0);
    send(0, 8'h3C, 0, -1, 0);
    send(0, 8'hC3, 1, -1, 0);
    send(1, 8'($urandom), 0, 5, 0);
    send(1, 8'($urandom), 0, 11, 0);
    send(1, 8'($urandom), 1, 10, 0);
    for (int i = 0; i < 12; i++) begin
      send(int'($urandom % 2), 8'($urandom), bit'($urandom), -1, 0);
    end
    repeat (3) step();
    check("done_count0", done_seen[0], done_exp[0]);
    check("done_count1", done_seen[1], done_exp[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
